// File: rtl/alu_issue_stage_if.sv
// Decode-to-execute issue bus: decode-side handshake and fields in, registered
// ALU operands and control out toward execute.
interface alu_issue_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  ALUOp;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic        alu_src;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] imm;
   logic [4:0]  rd_in;
   logic        reg_write_in;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] oprd1;
   logic [31:0] oprd2;
   logic [3:0]  ALU_Operation;
   logic [4:0]  rd_out;
   logic        reg_write_out;
   logic        illegal;
   logic [7:0]  illegal_count;

   // Stage view
   modport slave (
      input  in_valid, ALUOp, funct3, funct7_5, alu_src, rs1_data, rs2_data, imm,
             rd_in, reg_write_in, flush, out_ready,
      output in_ready, out_valid, oprd1, oprd2, ALU_Operation, rd_out,
             reg_write_out, illegal, illegal_count
   );

   // Surrounding pipeline view
   modport master (
      output in_valid, ALUOp, funct3, funct7_5, alu_src, rs1_data, rs2_data, imm,
             rd_in, reg_write_in, flush, out_ready,
      input  in_ready, out_valid, oprd1, oprd2, ALU_Operation, rd_out,
             reg_write_out, illegal, illegal_count
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Single-entry registered issue stage: ALUOp/funct -> 4-bit ALU opcode,
// operand select, valid/ready handshake, flush, saturating illegal counter.
module alu_issue_stage (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   alu_issue_stage_if.slave      bus
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   typedef struct packed {
      logic [31:0] oprd1;
      logic [31:0] oprd2;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        rw;
      logic        ill;
   } payload_t;

   state_e   state_q, state_d;
   payload_t pl_q, pl_d;
   logic [7:0] cnt_q, cnt_d;
   logic     load;

   assign bus.out_valid = (state_q == FULL);
   assign bus.in_ready  = !bus.out_valid || bus.out_ready;
   // A flush cycle never loads, so the killed offer is neither held nor counted.
   assign load = bus.in_valid && bus.in_ready && !bus.flush;

   always_comb begin
      pl_d       = '0;
      pl_d.oprd1 = bus.rs1_data;
      pl_d.oprd2 = bus.alu_src ? bus.imm : bus.rs2_data;
      pl_d.rd    = bus.rd_in;
      pl_d.op    = 4'b0010;
      pl_d.ill   = 1'b0;
      unique case (bus.ALUOp)
         2'b00: pl_d.op = 4'b0010;
         2'b01: pl_d.op = 4'b0110;
         2'b10: begin
            unique case (bus.funct3)
               // I-type has no funct7, so bit 30 is part of the immediate there.
               3'b000: pl_d.op = (bus.funct7_5 && !bus.alu_src) ? 4'b0110 : 4'b0010;
               3'b111: pl_d.op = 4'b0000;
               3'b110: pl_d.op = 4'b0001;
               3'b100: pl_d.op = 4'b1000;
               3'b010: pl_d.op = 4'b0111;
               default: pl_d.ill = 1'b1;
            endcase
         end
         default: pl_d.ill = 1'b1;
      endcase
      pl_d.rw = bus.reg_write_in && !pl_d.ill;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (bus.flush)                          state_d = EMPTY;
      else if (load)                          state_d = FULL;
      else if (bus.out_valid && bus.out_ready) state_d = EMPTY;
      if (load && pl_d.ill && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
         pl_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) pl_q <= pl_d;
      end
   end

   assign bus.oprd1         = pl_q.oprd1;
   assign bus.oprd2         = pl_q.oprd2;
   assign bus.ALU_Operation = pl_q.op;
   assign bus.rd_out        = pl_q.rd;
   assign bus.reg_write_out = pl_q.rw;
   assign bus.illegal       = pl_q.ill;
   assign bus.illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table, handshake, flush,
// illegal-count saturation and asynchronous reset.
module tb_alu_issue_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   alu_issue_stage_if ifc ();

   alu_issue_stage dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (ifc.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] aop, input logic [2:0] f3,
                        input logic f7, input logic src, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im,
                        input logic [4:0] rd, input logic rw);
      ifc.in_valid     = v;
      ifc.ALUOp        = aop;
      ifc.funct3       = f3;
      ifc.funct7_5     = f7;
      ifc.alu_src      = src;
      ifc.rs1_data     = a;
      ifc.rs2_data     = b;
      ifc.imm          = im;
      ifc.rd_in        = rd;
      ifc.reg_write_in = rw;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ifc.flush = 1'b0;
      ifc.out_ready = 1'b1;
      drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
      step(); step();
      n_chk++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", ifc.out_valid); end
      n_chk++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", ifc.in_ready); end
      n_chk++; if (ifc.ALU_Operation !== 4'b0000) begin n_fail++; $display("FAIL reset_op got=%b exp=0000", ifc.ALU_Operation); end
      n_chk++; if (ifc.illegal_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", ifc.illegal_count); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_sub_addi();
      ifc.out_ready = 1'b1;
      drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 32'd7, 32'd3, 32'd99, 5'd4, 1'b1);
      step();
      n_chk++; if (ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL sub_valid got=%b exp=1", ifc.out_valid); end
      n_chk++; if (ifc.ALU_Operation !== 4'b0110) begin n_fail++; $display("FAIL sub_op got=%b exp=0110", ifc.ALU_Operation); end
      n_chk++; if (ifc.oprd1 !== 32'd7) begin n_fail++; $display("FAIL sub_oprd1 got=%0d exp=7", ifc.oprd1); end
      n_chk++; if (ifc.oprd2 !== 32'd3) begin n_fail++; $display("FAIL sub_oprd2 got=%0d exp=3", ifc.oprd2); end
      n_chk++; if (ifc.rd_out !== 5'd4 || ifc.reg_write_out !== 1'b1) begin n_fail++; $display("FAIL sub_wb got=%0d/%b exp=4/1", ifc.rd_out, ifc.reg_write_out); end
      drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b1, 32'd7, 32'd3, 32'hFFFF_FFFF, 5'd5, 1'b1);
      step();
      n_chk++; if (ifc.ALU_Operation !== 4'b0010) begin n_fail++; $display("FAIL addi_op got=%b exp=0010", ifc.ALU_Operation); end
      n_chk++; if (ifc.oprd2 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addi_oprd2 got=%h exp=ffffffff", ifc.oprd2); end
      n_chk++; if (ifc.illegal !== 1'b0) begin n_fail++; $display("FAIL addi_illegal got=%b exp=0", ifc.illegal); end
   endtask

   task automatic test_sweep();
      logic [1:0] aop [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
      logic [2:0] f3  [6] = '{3'b111, 3'b110, 3'b100, 3'b010, 3'b101, 3'b011};
      logic [3:0] exp [6] = '{4'b0000, 4'b0001, 4'b1000, 4'b0111, 4'b0010, 4'b0110};
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, aop[i], f3[i], 1'b1, 1'b0, 32'(i), 32'(i + 10), 0, 5'(i), 1'b1);
         step();
         n_chk++; if (ifc.ALU_Operation !== exp[i] || ifc.out_valid !== 1'b1 || ifc.illegal !== 1'b0)
            begin n_fail++; $display("FAIL sweep_%0d got=%b/%b/%b exp=%b/1/0", i, ifc.ALU_Operation, ifc.out_valid, ifc.illegal, exp[i]); end
      end
      drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
      step();
      n_chk++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_drain got=%b exp=0", ifc.out_valid); end
   endtask

   task automatic test_back_pressure();
      ifc.out_ready = 1'b1;
      drive(1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 32'hA, 32'hA1, 0, 5'd10, 1'b1);
      step();
      ifc.out_ready = 1'b0;
      drive(1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 32'hB, 32'hB1, 0, 5'd11, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d got=%b exp=0", i, ifc.in_ready); end
         step();
         n_chk++; if (ifc.out_valid !== 1'b1 || ifc.oprd1 !== 32'hA || ifc.ALU_Operation !== 4'b0000 || ifc.rd_out !== 5'd10)
            begin n_fail++; $display("FAIL bp_hold_%0d got=%b/%h/%b/%0d exp=1/a/0000/10", i, ifc.out_valid, ifc.oprd1, ifc.ALU_Operation, ifc.rd_out); end
      end
      ifc.out_ready = 1'b1;
      #1;
      n_chk++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", ifc.in_ready); end
      step();
      n_chk++; if (ifc.out_valid !== 1'b1 || ifc.oprd1 !== 32'hB || ifc.ALU_Operation !== 4'b0001)
         begin n_fail++; $display("FAIL bp_next got=%b/%h/%b exp=1/b/0001", ifc.out_valid, ifc.oprd1, ifc.ALU_Operation); end
      drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
      step();
      n_chk++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got=%b exp=0", ifc.out_valid); end
   endtask

   task automatic test_flush();
      ifc.out_ready = 1'b0;
      drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 32'h11, 32'h12, 0, 5'd1, 1'b1);
      step();
      n_chk++; if (ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre got=%b exp=1", ifc.out_valid); end
      ifc.out_ready = 1'b1;
      ifc.flush = 1'b1;
      drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 32'hCC, 32'hCD, 0, 5'd2, 1'b1);
      step();
      ifc.flush = 1'b0;
      n_chk++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", ifc.out_valid); end
      drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
      step();
      n_chk++; if (ifc.out_valid !== 1'b0 || ifc.oprd1 === 32'hCC)
         begin n_fail++; $display("FAIL flush_not_captured got=%b/%h exp=0/not cc", ifc.out_valid, ifc.oprd1); end
   endtask

   task automatic test_illegal();
      logic [7:0] exp_cnt;
      ifc.out_ready = 1'b1;
      drive(1'b1, 2'b10, 3'b001, 1'b0, 1'b0, 32'h5, 32'h6, 0, 5'd7, 1'b1);
      for (int i = 0; i < 260; i++) begin
         step();
         exp_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
         n_chk++; if (ifc.illegal !== 1'b1 || ifc.reg_write_out !== 1'b0 || ifc.ALU_Operation !== 4'b0010 || ifc.illegal_count !== exp_cnt)
            begin n_fail++; $display("FAIL illegal_%0d got=%b/%b/%b/%0d exp=1/0/0010/%0d", i, ifc.illegal, ifc.reg_write_out, ifc.ALU_Operation, ifc.illegal_count, exp_cnt); end
      end
      drive(1'b1, 2'b11, 3'b000, 1'b0, 1'b0, 0, 0, 0, 5'd8, 1'b1);
      step();
      n_chk++; if (ifc.illegal !== 1'b1 || ifc.reg_write_out !== 1'b0 || ifc.illegal_count !== 8'd255)
         begin n_fail++; $display("FAIL illegal_aluop11 got=%b/%b/%0d exp=1/0/255", ifc.illegal, ifc.reg_write_out, ifc.illegal_count); end
      drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
      step();
   endtask

   task automatic test_async_reset();
      ifc.out_ready = 1'b0;
      drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b0, 32'h77, 32'h88, 0, 5'd9, 1'b1);
      step();
      step();
      n_chk++; if (ifc.out_valid !== 1'b1 || ifc.ALU_Operation !== 4'b1000) begin n_fail++; $display("FAIL ar_pre got=%b/%b exp=1/1000", ifc.out_valid, ifc.ALU_Operation); end
      #1;
      rst_n = 1'b0;
      #1;
      n_chk++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_valid got=%b/%b exp=0/1", ifc.out_valid, ifc.in_ready); end
      n_chk++; if (ifc.oprd1 !== 0 || ifc.oprd2 !== 0 || ifc.ALU_Operation !== 4'b0000 || ifc.rd_out !== 0 ||
                   ifc.reg_write_out !== 1'b0 || ifc.illegal !== 1'b0 || ifc.illegal_count !== 8'd0)
         begin n_fail++; $display("FAIL ar_payload got=%h/%h/%b/%0d/%b/%b/%0d exp=all zero", ifc.oprd1, ifc.oprd2, ifc.ALU_Operation, ifc.rd_out, ifc.reg_write_out, ifc.illegal, ifc.illegal_count); end
      ifc.out_ready = 1'b1;
      step();
      n_chk++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_no_accept got=%b exp=0", ifc.out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      n_chk++; if (ifc.out_valid !== 1'b1 || ifc.oprd1 !== 32'h77) begin n_fail++; $display("FAIL ar_resume got=%b/%h exp=1/77", ifc.out_valid, ifc.oprd1); end
      drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
      step();
   endtask

   initial begin
      test_reset();
      test_sub_addi();
      test_sweep();
      test_back_pressure();
      test_flush();
      test_illegal();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
